// File: rtl/rgb565_pkg.sv
// -----------------------------------------------------------------------------
// rgb565_pkg
//   Shared constants, state encoding and saturation helpers for the
//   rgb565_stream_packer block.
//   Optional build macro: RGB565_ROUND_EN (used by pixel4_to_rgb565).
//   No ports (package).
// -----------------------------------------------------------------------------
package rgb565_pkg;

   // Beat geometry
   localparam int PIX_PER_BEAT_IN = 4;
   localparam int BEAT_IN_W       = 128;
   localparam int HALF_W          = 64;
   localparam int PIX_IN_W        = 32;
   localparam int PIX_OUT_W       = 16;
   localparam int KEEP_W          = BEAT_IN_W / 8;

   // Byte enables for a full output beat and for a flushed half beat
   localparam logic [KEEP_W-1:0] KEEP_FULL = 16'hFFFF;
   localparam logic [KEEP_W-1:0] KEEP_HALF = 16'h00FF;

   // Channel slices inside one 0BGR888 pixel word; bits [31:24] are ignored
   localparam int CH_W  = 8;
   localparam int B_LSB = 0;
   localparam int G_LSB = 8;
   localparam int R_LSB = 16;
   localparam int X_LSB = 24;

   // Packer state: whether a converted half beat is waiting for its partner
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HALF  = 1'b1
   } pack_state_e;

   // Clamp a rounded 6-bit quotient to a 5-bit channel
   function automatic logic [4:0] sat5(input logic [5:0] v);
      return v[5] ? 5'h1F : v[4:0];
   endfunction

   // Clamp a rounded 7-bit quotient to a 6-bit channel
   function automatic logic [5:0] sat6(input logic [6:0] v);
      return v[6] ? 6'h3F : v[5:0];
   endfunction

endpackage

// File: rtl/rgb565_stream_packer_if.sv
// -----------------------------------------------------------------------------
// rgb565_stream_packer_if
//   Bundles both AXI4-Stream legs seen by the packer.
//   Input leg  (s_axis_*): 128-bit beats of four 0BGR888 pixels, with tlast.
//   Output leg (m_axis_*): 128-bit beats of eight RGB565 pixels, tkeep, tlast.
//   Modports:
//     master - the packer: consumes s_axis_*, produces m_axis_* and s_axis_tready
//     slave  - the surrounding environment (upstream FIFO + downstream DMA)
// -----------------------------------------------------------------------------
interface rgb565_stream_packer_if;

   logic [rgb565_pkg::BEAT_IN_W-1:0] s_axis_tdata;
   logic                             s_axis_tvalid;
   logic                             s_axis_tready;
   logic                             s_axis_tlast;

   logic [rgb565_pkg::BEAT_IN_W-1:0] m_axis_tdata;
   logic [rgb565_pkg::KEEP_W-1:0]    m_axis_tkeep;
   logic                             m_axis_tvalid;
   logic                             m_axis_tready;
   logic                             m_axis_tlast;

   modport master (
      input  s_axis_tdata,
      input  s_axis_tvalid,
      input  s_axis_tlast,
      output s_axis_tready,
      output m_axis_tdata,
      output m_axis_tkeep,
      output m_axis_tvalid,
      output m_axis_tlast,
      input  m_axis_tready
   );

   modport slave (
      output s_axis_tdata,
      output s_axis_tvalid,
      output s_axis_tlast,
      input  s_axis_tready,
      input  m_axis_tdata,
      input  m_axis_tkeep,
      input  m_axis_tvalid,
      input  m_axis_tlast,
      output m_axis_tready
   );

endinterface

// File: rtl/pixel4_to_rgb565.sv
// -----------------------------------------------------------------------------
// pixel4_to_rgb565
//   Purely combinational conversion of four 0BGR888 pixels to RGB565.
//   Pixel i of i_data[32i+31:32i] lands in o_data[16i+15:16i].
//   Build option RGB565_ROUND_EN: round-to-nearest with saturation per channel
//   instead of plain truncation.
//   Ports:
//     i_data  in  128  four 0BGR888 pixels (B in [7:0], G [15:8], R [23:16])
//     o_data  out 64   four RGB565 pixels
// -----------------------------------------------------------------------------
module pixel4_to_rgb565
   import rgb565_pkg::*;
(
   input  logic [BEAT_IN_W-1:0] i_data,
   output logic [HALF_W-1:0]    o_data
);

   for (genvar i = 0; i < PIX_PER_BEAT_IN; i++) begin : g_pix
      logic [CH_W-1:0] w_r;
      logic [CH_W-1:0] w_g;
      logic [CH_W-1:0] w_b;
      logic            w_unused;

      assign w_r = i_data[PIX_IN_W*i + R_LSB +: CH_W];
      assign w_g = i_data[PIX_IN_W*i + G_LSB +: CH_W];
      assign w_b = i_data[PIX_IN_W*i + B_LSB +: CH_W];

`ifdef RGB565_ROUND_EN
      // 9-bit sums so 255+4 does not wrap; the carry drives saturation
      logic [8:0] w_r9;
      logic [8:0] w_g9;
      logic [8:0] w_b9;

      assign w_r9 = {1'b0, w_r} + 9'd4;
      assign w_g9 = {1'b0, w_g} + 9'd2;
      assign w_b9 = {1'b0, w_b} + 9'd4;

      assign o_data[PIX_OUT_W*i +: PIX_OUT_W] =
         {sat5(w_r9[8:3]), sat6(w_g9[8:2]), sat5(w_b9[8:3])};

      assign w_unused = ^{i_data[PIX_IN_W*i + X_LSB +: CH_W],
                          w_r9[2:0], w_g9[1:0], w_b9[2:0]};
`else
      assign o_data[PIX_OUT_W*i +: PIX_OUT_W] = {w_r[7:3], w_g[7:2], w_b[7:3]};

      assign w_unused = ^{i_data[PIX_IN_W*i + X_LSB +: CH_W],
                          w_r[2:0], w_g[1:0], w_b[2:0]};
`endif
   end

endmodule

// File: rtl/rgb565_stream_packer.sv
// -----------------------------------------------------------------------------
// rgb565_stream_packer
//   Converts 0BGR888 stream beats to RGB565 and packs two converted input
//   beats into one 128-bit output beat. A frame ending on an odd input beat is
//   flushed as a half beat (tkeep=00FF). Counts emitted frames and odd flushes.
//   Build option RGB565_ROUND_EN (rounded conversion) lives in pixel4_to_rgb565;
//   handshake and latency are the same in both builds.
//   Parameters:
//     CNT_W            width of the wrapping status counters
//   Ports:
//     clk              system clock
//     reset            synchronous, active-high reset
//     axis             stream bundle (master modport): s_axis_* in, m_axis_* out
//     frame_count      out CNT_W  tlast beats transferred on m_axis (wraps)
//     odd_flush_count  out CNT_W  frames that ended on a half beat (wraps)
// -----------------------------------------------------------------------------
module rgb565_stream_packer
   import rgb565_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   rgb565_stream_packer_if.master axis,
   output logic [CNT_W-1:0]      frame_count,
   output logic [CNT_W-1:0]      odd_flush_count
);

   logic [HALF_W-1:0]    w_conv;
   logic                 w_s_ready;
   logic                 w_accept;
   logic                 w_pop;

   pack_state_e          r_state;
   logic [HALF_W-1:0]    r_lo;
   logic [BEAT_IN_W-1:0] r_tdata;
   logic [KEEP_W-1:0]    r_tkeep;
   logic                 r_tvalid;
   logic                 r_tlast;
   logic [CNT_W-1:0]     r_frame_cnt;
   logic [CNT_W-1:0]     r_odd_cnt;

   pixel4_to_rgb565 u_conv (
      .i_data (axis.s_axis_tdata),
      .o_data (w_conv)
   );

   // Input may be taken whenever the output register is free or is leaving
   // this cycle. Every accepted beat either parks in r_lo or loads the output
   // register, so an unpopped output beat can never be overwritten.
   assign w_s_ready = !r_tvalid || axis.m_axis_tready;
   assign w_accept  = axis.s_axis_tvalid && w_s_ready;
   assign w_pop     = r_tvalid && axis.m_axis_tready;

   assign axis.s_axis_tready = w_s_ready;
   assign axis.m_axis_tdata  = r_tdata;
   assign axis.m_axis_tkeep  = r_tkeep;
   assign axis.m_axis_tvalid = r_tvalid;
   assign axis.m_axis_tlast  = r_tlast;
   assign frame_count        = r_frame_cnt;
   assign odd_flush_count    = r_odd_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_EMPTY;
         r_lo        <= '0;
         r_tdata     <= '0;
         r_tkeep     <= '0;
         r_tvalid    <= 1'b0;
         r_tlast     <= 1'b0;
         r_frame_cnt <= '0;
         r_odd_cnt   <= '0;
      end else begin
         // Pop first; a load below in the same cycle overrides the clear,
         // which is what keeps back-to-back output beats bubble-free.
         if (w_pop) begin
            r_tvalid <= 1'b0;
            if (r_tlast) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
         end

         if (w_accept) begin
            case (r_state)
               ST_EMPTY: begin
                  if (axis.s_axis_tlast) begin
                     // Frame ends on a lone half: flush it without a partner
                     r_tdata   <= {{HALF_W{1'b0}}, w_conv};
                     r_tkeep   <= KEEP_HALF;
                     r_tlast   <= 1'b1;
                     r_tvalid  <= 1'b1;
                     r_odd_cnt <= r_odd_cnt + CNT_W'(1);
                  end else begin
                     r_lo    <= w_conv;
                     r_state <= ST_HALF;
                  end
               end
               ST_HALF: begin
                  // Earlier half in the low 64 bits keeps pixel order
                  r_tdata  <= {w_conv, r_lo};
                  r_tkeep  <= KEEP_FULL;
                  r_tlast  <= axis.s_axis_tlast;
                  r_tvalid <= 1'b1;
                  r_state  <= ST_EMPTY;
               end
               default: r_state <= ST_EMPTY;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rgb565_stream_packer.sv
module tb_rgb565_stream_packer;
   import rgb565_pkg::*;

   // Narrow counters so wrap-around is reached within the random run
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rgb565_stream_packer_if bus();
   logic [CNT_W-1:0] frame_count;
   logic [CNT_W-1:0] odd_flush_count;

   rgb565_stream_packer #(.CNT_W(CNT_W)) dut (
      .clk             (clk),
      .reset           (reset),
      .axis            (bus.master),
      .frame_count     (frame_count),
      .odd_flush_count (odd_flush_count)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [127:0] d;
      logic [15:0]  k;
      logic         l;
   } beat_t;

   logic [15:0] pix_q[$];
   beat_t       exp_q[$];
   int          mdl_frames = 0;
   int          mdl_odd    = 0;

   function automatic logic [15:0] ref565(input logic [31:0] p);
      int r, g, b;
      r = int'(p[23:16]);
      g = int'(p[15:8]);
      b = int'(p[7:0]);
`ifdef RGB565_ROUND_EN
      r = (r + 4) / 8; if (r > 31) r = 31;
      g = (g + 2) / 4; if (g > 63) g = 63;
      b = (b + 4) / 8; if (b > 31) b = 31;
`else
      r = r / 8;
      g = g / 4;
      b = b / 8;
`endif
      return 16'(r * 2048 + g * 32 + b);
   endfunction

   // Pixels accumulate in a flat list; a beat is emitted at 8 pixels or at
   // end of frame, with tkeep covering exactly the pixels present.
   task automatic model_accept(input logic [127:0] d, input logic l);
      beat_t b;
      for (int i = 0; i < 4; i++) pix_q.push_back(ref565(d[32*i +: 32]));
      if (l && pix_q.size() == 4) mdl_odd++;
      if (l || pix_q.size() == 8) begin
         b.d = '0;
         foreach (pix_q[k]) b.d[16*k +: 16] = pix_q[k];
         b.k = 16'((1 << (2 * pix_q.size())) - 1);
         b.l = l;
         exp_q.push_back(b);
         pix_q.delete();
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   int     out_cnt    = 0;
   int     streak     = 0;
   int     max_streak = 0;
   beat_t  last_out;
   logic   held_valid = 1'b0;
   logic [145:0] held;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset) begin
         pix_q.delete();
         exp_q.delete();
         mdl_frames = 0;
         mdl_odd    = 0;
         held_valid = 1'b0;
         streak     = 0;
      end else begin
         check("s_ready_rule", 160'(bus.s_axis_tready),
               160'(!bus.m_axis_tvalid || bus.m_axis_tready));
         if (held_valid)
            check("stall_stable",
                  160'({bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast}),
                  160'(held));
         held_valid = bus.m_axis_tvalid && !bus.m_axis_tready;
         held = {bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tkeep, bus.m_axis_tlast};

         if (bus.s_axis_tvalid && bus.s_axis_tready)
            model_accept(bus.s_axis_tdata, bus.s_axis_tlast);

         if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            out_cnt++;
            streak++;
            if (streak > max_streak) max_streak = streak;
            last_out = '{d: bus.m_axis_tdata, k: bus.m_axis_tkeep, l: bus.m_axis_tlast};
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_out: got %0h with nothing expected", bus.m_axis_tdata);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               if (e.l) mdl_frames++;
               if (e != last_out) begin
                  failures++;
                  $display("FAIL out_beat: got d=%0h k=%0h l=%0b expected d=%0h k=%0h l=%0b",
                           last_out.d, last_out.k, last_out.l, e.d, e.k, e.l);
               end
            end
         end else begin
            streak = 0;
         end
      end
   end

   // ---------------- downstream ready driver ----------------
   int rdy_mode = 0;
   int pat_i    = 0;

   initial begin
      bus.m_axis_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            1: begin
               bus.m_axis_tready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
               pat_i++;
            end
            2:       bus.m_axis_tready = ($urandom_range(0, 3) != 0);
            default: bus.m_axis_tready = 1'b1;
         endcase
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [127:0] d, input logic l);
      int   n = 0;
      logic acc;
      bus.s_axis_tdata  = d;
      bus.s_axis_tlast  = l;
      bus.s_axis_tvalid = 1'b1;
      forever begin
         @(negedge clk);
         acc = bus.s_axis_tready;
         @(posedge clk); #1;
         if (acc) break;
         n++;
         if (n > 200) begin
            checks++; failures++;
            $display("FAIL send_timeout: input not accepted within 200 cycles");
            break;
         end
      end
      bus.s_axis_tvalid = 1'b0;
   endtask

   task automatic wait_outs(input int target, input string name);
      int n = 0;
      while (out_cnt < target && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 160'(out_cnt), 160'(target));
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((bus.m_axis_tvalid || exp_q.size() != 0) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 160'(exp_q.size()), 160'(0));
   endtask

   task automatic check_counters(input string tag);
      @(negedge clk);
      check({tag, "_frame_count"}, 160'(frame_count), 160'(CNT_W'(mdl_frames)));
      check({tag, "_odd_count"}, 160'(odd_flush_count), 160'(CNT_W'(mdl_odd)));
      @(posedge clk); #1;
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [127:0] din;
      logic [63:0]  exp;
   } vec_t;

   vec_t tbl[4];

   initial begin
      int base;
      int t0;

      tbl[0].din = {32'h00FFFFFF, 32'h000000FF, 32'h0000FF00, 32'h00000000};
      tbl[0].exp = 64'hFFFF_001F_07E0_0000;
      tbl[1].din = {32'hAB808080, 32'h00123456, 32'h00FDFEFD, 32'h00040205};
      tbl[2].din = {32'h00FF0000, 32'h00080408, 32'h00F8FCF8, 32'h00070307};
`ifdef RGB565_ROUND_EN
      tbl[1].exp = 64'h8410_11AB_FFFF_0821;
      tbl[2].exp = 64'hF800_0821_FFFF_0821;
`else
      tbl[1].exp = 64'h8410_11AA_FFFF_0000;
      tbl[2].exp = 64'hF800_0821_FFFF_0000;
`endif
      tbl[3].din = {4{32'hFF000000}};
      tbl[3].exp = 64'h0;

      reset             = 1'b1;
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = '0;
      bus.s_axis_tlast  = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      @(negedge clk);
      check("rst_tvalid", 160'(bus.m_axis_tvalid), 160'(0));
      check("rst_tdata", 160'(bus.m_axis_tdata), 160'(0));
      check("rst_tkeep", 160'(bus.m_axis_tkeep), 160'(0));
      check("rst_tlast", 160'(bus.m_axis_tlast), 160'(0));
      check("rst_frame_count", 160'(frame_count), 160'(0));
      check("rst_odd_count", 160'(odd_flush_count), 160'(0));
      check("rst_s_tready", 160'(bus.s_axis_tready), 160'(1));
      @(posedge clk); #1;
      reset = 1'b0;

      // Two-beat frame
      send({4{32'h00FFFFFF}}, 1'b0);
      send({4{32'h00FF0000}}, 1'b1);
      wait_outs(1, "t1_count");
      check("t1_tdata", 160'(last_out.d), 160'(128'hF800F800F800F800_FFFFFFFFFFFFFFFF));
      check("t1_tkeep", 160'(last_out.k), 160'(16'hFFFF));
      check("t1_tlast", 160'(last_out.l), 160'(1));
      check("t1_frame_count", 160'(frame_count), 160'(1));

      // Table: single-beat frames, each a half-beat flush
      for (int i = 0; i < 4; i++) begin
         base = out_cnt;
         send(tbl[i].din, 1'b1);
         wait_outs(base + 1, "tbl_count");
         check("tbl_tdata", 160'(last_out.d), 160'({64'h0, tbl[i].exp}));
         check("tbl_tkeep", 160'(last_out.k), 160'(16'h00FF));
         check("tbl_tlast", 160'(last_out.l), 160'(1));
         if (i == 0) check("t2_odd_count", 160'(odd_flush_count), 160'(1));
      end
      check_counters("tbl");

      // 6-beat frame under a 1,0,0,1 ready pattern
      rdy_mode = 1;
      pat_i    = 0;
      base     = out_cnt;
      for (int i = 0; i < 6; i++)
         send({$urandom, $urandom, $urandom, $urandom}, i == 5);
      wait_outs(base + 3, "t3_count");
      drain("t3_drain");
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      check_counters("t3");

      // Continuous 8-beat stream: no input stalls, 4 outputs
      base = out_cnt;
      t0   = cyc;
      for (int i = 0; i < 8; i++)
         send({$urandom, $urandom, $urandom, $urandom}, i == 7);
      check("t4_in_cycles", 160'(cyc - t0), 160'(8));
      wait_outs(base + 4, "t4_count");
      drain("t4_drain");
      repeat (2) @(posedge clk);
      #1;

      // Back-to-back half flushes: pop and load overlap every cycle
      max_streak = 0;
      base       = out_cnt;
      for (int i = 0; i < 4; i++)
         send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
      wait_outs(base + 4, "b2b_count");
      check("b2b_streak", 160'(max_streak), 160'(4));
      drain("b2b_drain");

      // Reset while a half is pending
      send({4{32'h00FFFFFF}}, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("t5_tvalid", 160'(bus.m_axis_tvalid), 160'(0));
      check("t5_frame_count", 160'(frame_count), 160'(0));
      check("t5_odd_count", 160'(odd_flush_count), 160'(0));
      check("t5_s_tready", 160'(bus.s_axis_tready), 160'(1));
      @(posedge clk); #1;
      base = out_cnt;
      send({4{32'h000000FF}}, 1'b0);
      send({4{32'h0000FF00}}, 1'b1);
      wait_outs(base + 1, "t5_count");
      check("t5_tdata", 160'(last_out.d), 160'({{4{16'h07E0}}, {4{16'h001F}}}));
      check("t5_tkeep", 160'(last_out.k), 160'(16'hFFFF));
      check_counters("t5");

      // Randomized traffic with backpressure and wrap-around counters
      rdy_mode = 2;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         send({$urandom, $urandom, $urandom, $urandom},
              (i == 299) || ($urandom_range(0, 4) == 0));
      end
      rdy_mode = 0;
      drain("rand_drain");
      repeat (2) @(posedge clk);
      #1;
      check_counters("rand");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
